imr_adc_7476a_mc_axi: RTL and testbench
=======================================

// Module: imr_adc_7476a_mc_axi
// PURPOSE
//  AXI4-Lite multi-channel controller for AD7476A/7477A/7478A serial ADCs (12/10/8-bit).
//  NUM_CH converters share one CS_N/SCLK and each has its own SDATA line. Frames run single-shot or
//  continuously at a programmable interval. Latest sample per channel is held with NEW/overrun flags.
//  Sits under the PS AXI interconnect, replacing the fixed single-channel 4-register ADC IP.
// PARAMETERS
//  NUM_CH              2   converters sharing CS_N/SCLK, 1..12
//  ADC_RES             12  converter resolution: 12, 10 or 8
//  C_S_AXI_DATA_WIDTH  32  AXI data width, fixed 32
//  C_S_AXI_ADDR_WIDTH  6   byte address width, covers 0x00..0x3C
//  CLKDIV_RST          4   reset value of CLKDIV.HALF
// PORTS
//  s00_axi_aclk     in   1       system clock, all logic on rising edge
//  s00_axi_aresetn  in   1       asynchronous active-low reset
//  s00_axi_aw*/w*/b*/ar*/r*  -   AXI4-Lite slave (awaddr, awprot, awvalid/ready, wdata, wstrb, wvalid/ready,
//                                bresp, bvalid/ready, araddr, arprot, arvalid/ready, rdata, rresp, rvalid/ready)
//  adc_cs_n         out  1       shared chip select, idle high
//  adc_sclk         out  1       shared serial clock, idle high
//  adc_sdata        in   NUM_CH  per-channel serial data, MSB first
//  irq              out  1       level interrupt = CTRL.IRQ_EN & STATUS.DONE
// BEHAVIOUR
//  Reset values: cs_n=1, sclk=1, irq=0, all AXI valid/ready outputs=0, registers=0 except CLKDIV.HALF=CLKDIV_RST.
//  Register map (32-bit, byte offsets):
//   0x00 CTRL    [0] EN continuous, [1] START self-clearing 1 cycle, [2] IRQ_EN
//   0x04 STATUS  [0] BUSY (RO), [1] DONE W1C, [2] OVERRUN W1C
//   0x08 CLKDIV  [7:0] HALF = SCLK half-period in ACLK cycles minus 1; values 0 are forced to 1
//                [31:16] INTERVAL = ACLK cycles from one frame start to the next (continuous mode)
//   0x0C COUNT   32-bit completed-frame counter, RO, wraps at 2^32
//   0x10+4k DATA_k  [ADC_RES-1:0] sample, [31] NEW; NEW clears on the AXI read of that register
//  Unmapped reads return 0. Unmapped writes are ignored. BRESP/RRESP are always OKAY.
//  AXI handshake: AW and W are accepted together in one cycle when both valid and no B is pending.
//  At most one write and one read outstanding. Read data is returned 1 cycle after AR acceptance.
//  Sequencer FSM:
//   IDLE   -> SETUP  on START=1, or on EN=1 with the interval counter expired
//   SETUP  -> SHIFT  after one half-period (cs_n low, sclk high)
//   SHIFT  -> 16 SCLK periods; sclk toggles every HALF+1 cycles; falling edge first
//   SHIFT  -> QUIET  after the 16th rising edge
//   QUIET  -> IDLE   after 2 half-periods with cs_n high (tQUIET)
//  BUSY=1 in every state except IDLE.
//  adc_sdata is registered once; each bit is shifted in 1 ACLK cycle after the internal SCLK rising edge.
//  Frame format: 4 leading zeros, then ADC_RES data bits, then trailing zeros.
//   sample = shift[11 -: ADC_RES].
//  Frame end (QUIET entry) produces a 1-cycle update:
//   - every DATA_k is written and NEW_k is set
//   - COUNT is incremented and DONE is set
//   - if any NEW_k was already 1, OVERRUN is set
//  Interval counter restarts at SETUP entry. If INTERVAL < frame length, the next frame starts at IDLE (back-to-back).
//  CLKDIV, EN and START changes mid-frame take effect only at the next IDLE.
//  Clearing EN mid-frame completes the current frame.
//  START while BUSY is ignored.
//  Simultaneous events:
//   - frame update and read of DATA_k in the same cycle: update wins, NEW_k stays 1
//   - hardware set and W1C of DONE/OVERRUN in the same cycle: set wins
//  Asynchronous reset mid-frame: cs_n=1 and sclk=1 immediately; the partial frame is discarded.
// STRUCTURE
//  imr_adc_7476a_pkg: FSM state enum, register offset localparams, CTRL/STATUS bit indices, FRAME_BITS=16.
//  Sub-module imr_adc_7476a_serial_engine:
//   - contains the FSM, SCLK divider, interval counter and NUM_CH shift registers
//   - outputs sample bus plus frame_done strobe
//  The top holds the AXI4-Lite slave and the register file.
// TESTING
//  1. NUM_CH=2, HALF=4, START; ch0 bits 0x0ABC, ch1 bits 0x0123 -> DATA_0=0x80000ABC, DATA_1=0x80000123, COUNT=1, DONE=1.
//  2. Read DATA_0 twice -> 0x80000ABC then 0x00000ABC. Write STATUS=0x2 -> DONE=0, irq falls.
//  3. EN=1, INTERVAL=200, HALF=1, never read -> frames start 200 cycles apart; OVERRUN=1 after frame 2; COUNT increments.
//  4. ADC_RES=10, frame bits 0000_1111111111_00 -> DATA_0[9:0]=0x3FF, DATA_0[31]=1, bits [30:10]=0.
//  5. aresetn low during SHIFT -> cs_n=1 and sclk=1 the same cycle; all registers reset; COUNT=0.
//  6. Write CLKDIV mid-frame -> current frame keeps old SCLK period; next frame uses new. Unmapped read 0x3C (NUM_CH=2) -> 0.

Source files
------------

// File: rtl/imr_adc_7476a_pkg.sv
// Shared constants, register map and helpers for the multi-channel AD7476A controller.
`timescale 1ns/1ps
package imr_adc_7476a_pkg;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_QUIET = 2'd3;

  // Word indices (byte offset >> 2)
  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_CLKDIV = 4'd2;
  localparam logic [3:0] REG_COUNT  = 4'd3;
  localparam int         REG_DATA0  = 4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_START  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_OVR    = 2;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/imr_adc_7476a_serial_engine.sv
// Frame sequencer: shared CS_N/SCLK generation, interval timer and per-channel sample capture.
`timescale 1ns/1ps
module imr_adc_7476a_serial_engine
  import imr_adc_7476a_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADC_RES = 12
) (
  input  logic                             gclk,
  input  logic                             grst_n,
  input  logic                             en,
  input  logic                             start,
  input  logic [7:0]                       half,
  input  logic [15:0]                      interval,
  input  logic [NUM_CH-1:0]                sdata,
  output logic                             cs_n,
  output logic                             sclk,
  output logic                             busy,
  output logic                             frame_done,
  output logic [NUM_CH-1:0][ADC_RES-1:0]   sample
);

  logic [1:0]        state;
  logic [7:0]        half_q;
  logic [7:0]        div_cnt;
  logic [4:0]        rise_cnt;
  logic [16:0]       ivl_cnt;
  logic [NUM_CH-1:0] sdata_q;
  logic              cap_d;
  logic [1:0]        vld_pipe;

  logic tick, go, rise, last_rise, cap, ivl_expired;

  assign tick        = (div_cnt == half_q);
  assign ivl_expired = (ivl_cnt + 17'd1) >= {1'b0, interval};
  assign go          = (state == ST_IDLE) && (start || (en && ivl_expired));
  assign rise        = (state == ST_SHIFT) && tick && !sclk;
  assign last_rise   = rise && (rise_cnt == 5'd15);
  // Only the rising edges that carry data bits are captured; lead/trail zeros fall through.
  assign cap         = rise && (rise_cnt >= 5'(LEAD_BITS)) && (rise_cnt < 5'(LEAD_BITS + ADC_RES));
  assign busy        = (state != ST_IDLE);
  assign frame_done  = vld_pipe[1];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state    <= ST_IDLE;
      cs_n     <= 1'b1;
      sclk     <= 1'b1;
      half_q   <= 8'd1;
      div_cnt  <= '0;
      rise_cnt <= '0;
      ivl_cnt  <= '0;
      sdata_q  <= '0;
      cap_d    <= 1'b0;
      vld_pipe <= '0;
    end else begin
      sdata_q  <= sdata;
      cap_d    <= cap;
      vld_pipe <= {vld_pipe[0], last_rise};
      if (go)                ivl_cnt <= '0;
      else if (!ivl_cnt[16]) ivl_cnt <= ivl_cnt + 17'd1;

      case (state)
        ST_IDLE: begin
          div_cnt <= '0;
          if (go) begin
            state    <= ST_SETUP;
            cs_n     <= 1'b0;
            sclk     <= 1'b1;
            rise_cnt <= '0;
            half_q   <= (half == 8'd0) ? 8'd1 : half;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            state   <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
              rise_cnt <= rise_cnt + 5'd1;
              if (rise_cnt == 5'd15) begin
                state <= ST_QUIET;
                cs_n  <= 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          // rise_cnt enters at 16 and counts the two quiet half-periods
          if (tick) begin
            div_cnt <= '0;
            if (rise_cnt == 5'd17) state <= ST_IDLE;
            else                   rise_cnt <= rise_cnt + 5'd1;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic [ADC_RES-1:0] shreg;
    always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n)    shreg <= '0;
      else if (go)    shreg <= '0;
      else if (cap_d) shreg <= {shreg[ADC_RES-2:0], sdata_q[i]};
    end
    assign sample[i] = shreg;
  end

endmodule

// File: rtl/imr_adc_7476a_mc_axi.sv
// AXI4-Lite register front-end for NUM_CH AD7476A-family converters sharing CS_N/SCLK.
`timescale 1ns/1ps
module imr_adc_7476a_mc_axi
  import imr_adc_7476a_pkg::*;
#(
  parameter int NUM_CH             = 2,
  parameter int ADC_RES            = 12,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int CLKDIV_RST         = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            adc_cs_n,
  output logic                            adc_sclk,
  input  logic [NUM_CH-1:0]               adc_sdata,
  output logic                            irq
);

  logic aw_rdy, bvalid_q, ar_rdy, rvalid_q;
  logic [31:0] rdata_q, rd_word, cd_wr;
  logic wr_en, rd_en;
  logic [3:0] rd_idx;
  wr_req_t wr;

  logic en_q, irq_en_q, start_q, done_q, ovr_q;
  logic [7:0]  half_q;
  logic [15:0] ivl_q;
  logic [31:0] count_q;
  logic [NUM_CH-1:0][ADC_RES-1:0] data_q;
  logic [NUM_CH-1:0]              new_q;
  logic [1:0] w1c;

  logic busy, frame_done;
  logic [NUM_CH-1:0][ADC_RES-1:0] sample;

  assign wr     = '{idx: s00_axi_awaddr[5:2], data: s00_axi_wdata, strb: s00_axi_wstrb};
  assign rd_idx = s00_axi_araddr[5:2];
  assign wr_en  = aw_rdy & s00_axi_awvalid & s00_axi_wvalid;
  assign rd_en  = ar_rdy & s00_axi_arvalid;
  assign cd_wr  = apply_wstrb({ivl_q, 8'h00, half_q}, wr.data, wr.strb);
  assign w1c    = (wr_en && wr.idx == REG_STATUS && wr.strb[0]) ? wr.data[STAT_OVR:STAT_DONE] : 2'b00;

  assign s00_axi_awready = aw_rdy;
  assign s00_axi_wready  = aw_rdy;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = ar_rdy;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign irq             = irq_en_q & done_q;

  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                         s00_axi_araddr[1:0], cd_wr[15:8]};

  // AW and W are taken together, and only while no B response is outstanding.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_rdy   <= 1'b0;
      bvalid_q <= 1'b0;
      ar_rdy   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      aw_rdy <= ~aw_rdy & s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
      if (wr_en)               bvalid_q <= 1'b1;
      else if (s00_axi_bready) bvalid_q <= 1'b0;
      ar_rdy <= ~ar_rdy & s00_axi_arvalid & ~rvalid_q;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (rd_idx)
      REG_CTRL:   rd_word = {29'd0, irq_en_q, 1'b0, en_q};
      REG_STATUS: rd_word = {29'd0, ovr_q, done_q, busy};
      REG_CLKDIV: rd_word = {ivl_q, 8'h00, half_q};
      REG_COUNT:  rd_word = count_q;
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (rd_idx == 4'(REG_DATA0 + k)) begin
            rd_word[31]          = new_q[k];
            rd_word[ADC_RES-1:0] = data_q[k];
          end
        end
      end
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      half_q   <= 8'(CLKDIV_RST);
      ivl_q    <= '0;
      count_q  <= '0;
      data_q   <= '0;
      new_q    <= '0;
    end else begin
      start_q <= 1'b0;
      if (wr_en && wr.idx == REG_CTRL && wr.strb[0]) begin
        en_q     <= wr.data[CTRL_EN];
        start_q  <= wr.data[CTRL_START];
        irq_en_q <= wr.data[CTRL_IRQ_EN];
      end
      if (wr_en && wr.idx == REG_CLKDIV) begin
        half_q <= (cd_wr[7:0] == 8'd0) ? 8'd1 : cd_wr[7:0];
        ivl_q  <= cd_wr[31:16];
      end
      // Hardware set wins over a same-cycle W1C.
      done_q <= frame_done | (done_q & ~w1c[0]);
      ovr_q  <= (frame_done & (|new_q)) | (ovr_q & ~w1c[1]);
      if (frame_done) count_q <= count_q + 32'd1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (frame_done) begin
          data_q[k] <= sample[k];
          new_q[k]  <= 1'b1;
        end else if (rd_en && rd_idx == 4'(REG_DATA0 + k)) begin
          new_q[k]  <= 1'b0;
        end
      end
    end
  end

  imr_adc_7476a_serial_engine #(
    .NUM_CH  (NUM_CH),
    .ADC_RES (ADC_RES)
  ) u_engine (
    .gclk       (s00_axi_aclk),
    .grst_n     (s00_axi_aresetn),
    .en         (en_q),
    .start      (start_q),
    .half       (half_q),
    .interval   (ivl_q),
    .sdata      (adc_sdata),
    .cs_n       (adc_cs_n),
    .sclk       (adc_sclk),
    .busy       (busy),
    .frame_done (frame_done),
    .sample     (sample)
  );

endmodule

// File: tb/tb_imr_adc_7476a_mc_axi.sv
// Directed bench: 2-channel 12-bit instance plus a 1-channel 10-bit instance on a shared AXI bus.
`timescale 1ns/1ps
module tb_imr_adc_7476a_mc_axi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic [5:0]  awaddr, araddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  awvalid, wvalid, arvalid;
  logic        bready, rready;
  logic [1:0]  awready, wready, bvalid, arready, rvalid, cs_n, sclk, irq;
  logic [1:0][1:0]  bresp, rresp;
  logic [1:0][31:0] rdata;
  logic [1:0]  sd0;
  logic [0:0]  sd1;
  logic [1:0][15:0] frm0;
  logic [15:0] frm1;
  int bi0, bi1, nf;
  int n_cmp, n_err;
  longint t_fall0, t_low0;
  longint tf [8];

  imr_adc_7476a_mc_axi #(.NUM_CH(2), .ADC_RES(12)) u_dut0 (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid[0]), .s00_axi_awready(awready[0]),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid[0]), .s00_axi_wready(wready[0]),
    .s00_axi_bresp(bresp[0]), .s00_axi_bvalid(bvalid[0]), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid[0]), .s00_axi_arready(arready[0]),
    .s00_axi_rdata(rdata[0]), .s00_axi_rresp(rresp[0]), .s00_axi_rvalid(rvalid[0]), .s00_axi_rready(rready),
    .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .adc_sdata(sd0), .irq(irq[0]));

  imr_adc_7476a_mc_axi #(.NUM_CH(1), .ADC_RES(10)) u_dut1 (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid[1]), .s00_axi_awready(awready[1]),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid[1]), .s00_axi_wready(wready[1]),
    .s00_axi_bresp(bresp[1]), .s00_axi_bvalid(bvalid[1]), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid[1]), .s00_axi_arready(arready[1]),
    .s00_axi_rdata(rdata[1]), .s00_axi_rresp(rresp[1]), .s00_axi_rvalid(rvalid[1]), .s00_axi_rready(rready),
    .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .adc_sdata(sd1), .irq(irq[1]));

  // Converter models: MSB of the 16-bit frame appears on the first SCLK falling edge.
  always @(negedge cs_n[0]) begin
    bi0 = 15;
    t_fall0 = $time;
    if (nf < 8) begin tf[nf] = $time; nf++; end
  end
  always @(posedge cs_n[0]) t_low0 = $time - t_fall0;
  always @(negedge sclk[0]) if (!cs_n[0] && bi0 >= 0) begin
    sd0[0] = frm0[0][bi0];
    sd0[1] = frm0[1][bi0];
    bi0--;
  end
  always @(negedge cs_n[1]) bi1 = 15;
  always @(negedge sclk[1]) if (!cs_n[1] && bi1 >= 0) begin
    sd1[0] = frm1[bi1];
    bi1--;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_wr(input int sel, input logic [5:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = 4'hF;
    awvalid[sel] = 1'b1; wvalid[sel] = 1'b1;
    @(negedge clk);
    while (!awready[sel] && n < 20) begin @(negedge clk); n++; end
    if (!awready[sel]) chk("wr_timeout", {31'd0, awready[sel]}, 32'd1);
    @(posedge clk);
    #1 awvalid[sel] = 1'b0; wvalid[sel] = 1'b0;
  endtask

  task automatic axi_rd(input int sel, input logic [5:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    araddr = a; arvalid[sel] = 1'b1;
    @(negedge clk);
    while (!arready[sel] && n < 20) begin @(negedge clk); n++; end
    if (!arready[sel]) chk("rd_timeout", {31'd0, arready[sel]}, 32'd1);
    @(posedge clk);
    #1 arvalid[sel] = 1'b0;
    @(negedge clk);
    if (!rvalid[sel]) chk("rvalid", {31'd0, rvalid[sel]}, 32'd1);
    d = rdata[sel];
  endtask

  task automatic rd_chk(input int sel, input logic [5:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    axi_rd(sel, a, d);
    chk(tag, d, exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    n_cmp = 0; n_err = 0; nf = 0; bi0 = -1; bi1 = -1;
    aresetn = 1'b0; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = '0; wvalid = '0; arvalid = '0; bready = 1'b1; rready = 1'b1;
    sd0 = '0; sd1 = '0; frm0 = '0; frm1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_pins", 32'({cs_n[0], sclk[0], irq[0], awready[0], arready[0], bvalid[0], rvalid[0]}), 32'b1100000);
    aresetn = 1'b1;
    @(negedge clk);
    rd_chk(0, 6'h08, 32'h0000_0004, "rst_clkdiv");
    rd_chk(0, 6'h0C, 32'h0000_0000, "rst_count");
    rd_chk(0, 6'h04, 32'h0000_0000, "rst_status");

    // Single-shot frame, HALF=4
    frm0[0] = 16'h0ABC; frm0[1] = 16'h0123;
    axi_wr(0, 6'h00, 32'h6);
    rd_chk(0, 6'h04, 32'h0000_0001, "busy");
    repeat (300) @(negedge clk);
    rd_chk(0, 6'h10, 32'h8000_0ABC, "t1_data0");
    rd_chk(0, 6'h14, 32'h8000_0123, "t1_data1");
    rd_chk(0, 6'h0C, 32'h0000_0001, "t1_count");
    rd_chk(0, 6'h04, 32'h0000_0002, "t1_done");
    rd_chk(0, 6'h00, 32'h0000_0004, "t1_ctrl");
    chk("t1_irq", {31'd0, irq[0]}, 32'd1);
    chk("t1_cs_low", 32'(t_low0), 32'd1600);

    // NEW clears on read; DONE W1C drops irq
    rd_chk(0, 6'h10, 32'h0000_0ABC, "t2_data0_old");
    axi_wr(0, 6'h04, 32'h2);
    rd_chk(0, 6'h04, 32'h0000_0000, "t2_status_clr");
    chk("t2_irq", {31'd0, irq[0]}, 32'd0);

    // CLKDIV written mid-frame only applies to the next frame
    frm0[0] = 16'h0555; frm0[1] = 16'h0AAA;
    axi_wr(0, 6'h00, 32'h6);
    repeat (30) @(negedge clk);
    axi_wr(0, 6'h08, 32'h0000_0000);
    repeat (300) @(negedge clk);
    chk("t6_old_div", 32'(t_low0), 32'd1600);
    rd_chk(0, 6'h10, 32'h8000_0555, "t6_data0");
    rd_chk(0, 6'h14, 32'h8000_0AAA, "t6_data1");
    rd_chk(0, 6'h08, 32'h0000_0001, "t6_half_forced");
    frm0[0] = 16'h0F0F; frm0[1] = 16'h00C3;
    axi_wr(0, 6'h00, 32'h6);
    repeat (150) @(negedge clk);
    chk("t6_new_div", 32'(t_low0), 32'd640);
    rd_chk(0, 6'h10, 32'h8000_0F0F, "t6b_data0");
    rd_chk(0, 6'h14, 32'h8000_00C3, "t6b_data1");
    rd_chk(0, 6'h0C, 32'h0000_0003, "t6_count");
    rd_chk(0, 6'h04, 32'h0000_0002, "t6_no_ovr");
    rd_chk(0, 6'h3C, 32'h0000_0000, "unmapped_3c");
    rd_chk(0, 6'h18, 32'h0000_0000, "unmapped_data2");

    // Continuous mode, INTERVAL=200, HALF=1, data never read
    repeat (250) @(negedge clk);
    axi_wr(0, 6'h04, 32'h6);
    axi_wr(0, 6'h08, 32'h00C8_0001);
    frm0[0] = 16'h0FFF; frm0[1] = 16'h0001;
    nf = 0;
    axi_wr(0, 6'h00, 32'h1);
    repeat (480) @(negedge clk);
    axi_wr(0, 6'h00, 32'h0);
    repeat (100) @(negedge clk);
    chk("t3_frames", 32'(nf), 32'd3);
    chk("t3_gap1", 32'(tf[1] - tf[0]), 32'd2000);
    chk("t3_gap2", 32'(tf[2] - tf[1]), 32'd2000);
    rd_chk(0, 6'h04, 32'h0000_0006, "t3_overrun");
    rd_chk(0, 6'h0C, 32'h0000_0006, "t3_count");
    rd_chk(0, 6'h10, 32'h8000_0FFF, "t3_data0");
    rd_chk(0, 6'h14, 32'h8000_0001, "t3_data1");

    // 10-bit converter: 0000_1111111111_00
    frm1 = 16'h0FFC;
    axi_wr(1, 6'h00, 32'h2);
    repeat (300) @(negedge clk);
    rd_chk(1, 6'h10, 32'h8000_03FF, "t4_res10");
    rd_chk(1, 6'h0C, 32'h0000_0001, "t4_count");

    // Asynchronous reset while shifting
    axi_wr(0, 6'h00, 32'h2);
    n = 0;
    @(negedge clk);
    while ((cs_n[0] || sclk[0]) && n < 40) begin @(negedge clk); n++; end
    chk("t5_in_shift", {30'd0, cs_n[0], sclk[0]}, 32'd0);
    aresetn = 1'b0;
    #1;
    chk("t5_async_pins", {30'd0, cs_n[0], sclk[0]}, 32'd3);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    rd_chk(0, 6'h0C, 32'h0000_0000, "t5_count");
    rd_chk(0, 6'h08, 32'h0000_0004, "t5_clkdiv");
    rd_chk(0, 6'h04, 32'h0000_0000, "t5_status");
    rd_chk(0, 6'h10, 32'h0000_0000, "t5_data0");
    repeat (200) @(negedge clk);
    rd_chk(0, 6'h0C, 32'h0000_0000, "t5_no_frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
